// File: rtl/variable_roundsat_pipe.sv
// Three-stage round + saturate pipe with a runtime-selectable output bit window.
// Optional saturation event counter is built when VARSAT_SAT_COUNTER_EN is defined.
module variable_roundsat_pipe #(
   parameter int IN_WIDTH   = 35,
   parameter int OUT_WIDTH  = 12,
   parameter int SEL_WIDTH  = 2,
   parameter int LSB_BASE   = 15,
   parameter int SEL_STEP   = 2,
   parameter int ROUND_MODE = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [SEL_WIDTH-1:0] sel,
   input  logic [IN_WIDTH-1:0]  ast_sink_data,
   input  logic [1:0]           ast_sink_error,
   input  logic                 ast_sink_valid,
   output logic [OUT_WIDTH-1:0] ast_source_data,
   output logic [1:0]           ast_source_error,
   output logic                 ast_source_valid,
   output logic                 sat_flag,
   input  logic                 sat_count_clr,
   output logic [CNT_WIDTH-1:0] sat_count
);

   // Stream semantics: there is no ready. Every cycle with ast_sink_valid=1 is a
   // sample transfer; ast_source_valid=1 marks exactly one result, three cycles later.

   localparam logic [IN_WIDTH:0] ONE_W = {{IN_WIDTH{1'b0}}, 1'b1};
   localparam logic signed [IN_WIDTH:0] MAX_Y = $signed((ONE_W << (OUT_WIDTH - 1)) - ONE_W);
   localparam logic signed [IN_WIDTH:0] MIN_Y = ~MAX_Y;
   localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

   if (LSB_BASE + OUT_WIDTH > IN_WIDTH) begin : g_bad_msb
      $error("variable_roundsat_pipe: LSB_BASE+OUT_WIDTH exceeds IN_WIDTH");
   end
   if (LSB_BASE - ((2 ** SEL_WIDTH) - 1) * SEL_STEP < 0) begin : g_bad_lsb
      $error("variable_roundsat_pipe: smallest window LSB is negative");
   end
   if (ROUND_MODE < 0 || ROUND_MODE > 2) begin : g_bad_mode
      $error("variable_roundsat_pipe: ROUND_MODE must be 0, 1 or 2");
   end

   function automatic int lsb_of(input logic [SEL_WIDTH-1:0] s);
      return LSB_BASE - int'(s) * SEL_STEP;
   endfunction

   // Stage 1 registers
   logic signed [IN_WIDTH-1:0] d1;
   logic [1:0]                 e1;
   logic [SEL_WIDTH-1:0]       s1;
   logic                       v1;

   // Stage 2 registers
   logic signed [IN_WIDTH:0]   sum2;
   logic [1:0]                 e2;
   logic [SEL_WIDTH-1:0]       s2;
   logic                       v2;

   // Stage 2 combinational rounding term
   int                         l1;
   logic signed [IN_WIDTH:0]   x_ext;
   logic [IN_WIDTH:0]          half;
   logic [IN_WIDTH:0]          rem_mask;
   logic signed [IN_WIDTH:0]   term;

   // Stage 3 combinational saturation
   int                         l2;
   logic signed [IN_WIDTH:0]   y;
   logic [OUT_WIDTH-1:0]       sat_data_c;
   logic                       sat_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d1 <= '0;
         e1 <= '0;
         s1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= ast_sink_valid;
         if (ast_sink_valid) begin
            d1 <= $signed(ast_sink_data);
            e1 <= ast_sink_error;
            s1 <= sel;
         end
      end
   end

   // Convergent mode drops the half-LSB term only on an exact tie with an even quotient.
   always_comb begin
      l1       = lsb_of(s1);
      x_ext    = {d1[IN_WIDTH-1], d1};
      half     = '0;
      rem_mask = '0;
      term     = '0;
      if (l1 > 0 && ROUND_MODE != 0) begin
         half     = ONE_W << (l1 - 1);
         rem_mask = (ONE_W << l1) - ONE_W;
         term     = $signed(half);
         if (ROUND_MODE == 2 && ((x_ext & rem_mask) == half) && !x_ext[l1]) begin
            term = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum2 <= '0;
         e2   <= '0;
         s2   <= '0;
         v2   <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            sum2 <= x_ext + term;
            e2   <= e1;
            s2   <= s1;
         end
      end
   end

   always_comb begin
      l2         = lsb_of(s2);
      y          = sum2 >>> l2;
      sat_c      = 1'b0;
      sat_data_c = y[OUT_WIDTH-1:0];
      if (y > MAX_Y) begin
         sat_c      = 1'b1;
         sat_data_c = OUT_MAX;
      end else if (y < MIN_Y) begin
         sat_c      = 1'b1;
         sat_data_c = OUT_MIN;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ast_source_data  <= '0;
         ast_source_error <= '0;
         ast_source_valid <= 1'b0;
         sat_flag         <= 1'b0;
      end else begin
         ast_source_valid <= v2;
         sat_flag         <= v2 & sat_c;
         if (v2) begin
            ast_source_data  <= sat_data_c;
            ast_source_error <= e2;
         end
      end
   end

`ifdef VARSAT_SAT_COUNTER_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   // Counts visible saturated outputs; clear beats increment, count sticks at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (sat_count_clr) begin
         cnt_q <= '0;
      end else if (ast_source_valid && sat_flag && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_q <= cnt_q + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
      end
   end

   assign sat_count = cnt_q;
`else
   logic unused_clr;
   assign unused_clr = sat_count_clr;
   assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_variable_roundsat_pipe.sv
// Directed + random bench for variable_roundsat_pipe; three instances cover all rounding modes.
// Counter checks follow VARSAT_SAT_COUNTER_EN.
module tb_variable_roundsat_pipe;

   localparam int IW = 35;
   localparam int OW = 12;
   localparam int SW = 2;
   localparam int CW = 16;
   localparam int EW = 2 + 3 * (OW + 1);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [SW-1:0] sel = '0;
   logic [IW-1:0] ast_sink_data = '0;
   logic [1:0]    ast_sink_error = '0;
   logic          ast_sink_valid = 1'b0;
   logic          sat_count_clr = 1'b0;

   logic [OW-1:0] data_m0, data_m1, data_m2, data_sm;
   logic [1:0]    err_m0, err_m1, err_m2, err_sm;
   logic          valid_m0, valid_m1, valid_m2, valid_sm;
   logic          flag_m0, flag_m1, flag_m2, flag_sm;
   logic [CW-1:0] cnt_m0, cnt_m1, cnt_m2;
   logic [3:0]    cnt_sm;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_e;
   int n_vec = 0;
   int n_err = 0;

   variable_roundsat_pipe #(.ROUND_MODE(0)) dut_m0 (
      .clk(clk), .reset_n(reset_n), .sel(sel), .ast_sink_data(ast_sink_data),
      .ast_sink_error(ast_sink_error), .ast_sink_valid(ast_sink_valid),
      .ast_source_data(data_m0), .ast_source_error(err_m0), .ast_source_valid(valid_m0),
      .sat_flag(flag_m0), .sat_count_clr(sat_count_clr), .sat_count(cnt_m0));

   variable_roundsat_pipe #(.ROUND_MODE(1)) dut_m1 (
      .clk(clk), .reset_n(reset_n), .sel(sel), .ast_sink_data(ast_sink_data),
      .ast_sink_error(ast_sink_error), .ast_sink_valid(ast_sink_valid),
      .ast_source_data(data_m1), .ast_source_error(err_m1), .ast_source_valid(valid_m1),
      .sat_flag(flag_m1), .sat_count_clr(sat_count_clr), .sat_count(cnt_m1));

   variable_roundsat_pipe #(.ROUND_MODE(2)) dut_m2 (
      .clk(clk), .reset_n(reset_n), .sel(sel), .ast_sink_data(ast_sink_data),
      .ast_sink_error(ast_sink_error), .ast_sink_valid(ast_sink_valid),
      .ast_source_data(data_m2), .ast_source_error(err_m2), .ast_source_valid(valid_m2),
      .sat_flag(flag_m2), .sat_count_clr(sat_count_clr), .sat_count(cnt_m2));

   variable_roundsat_pipe #(.ROUND_MODE(1), .CNT_WIDTH(4)) dut_sm (
      .clk(clk), .reset_n(reset_n), .sel(sel), .ast_sink_data(ast_sink_data),
      .ast_sink_error(ast_sink_error), .ast_sink_valid(ast_sink_valid),
      .ast_source_data(data_sm), .ast_source_error(err_sm), .ast_source_valid(valid_sm),
      .sat_flag(flag_sm), .sat_count_clr(sat_count_clr), .sat_count(cnt_sm));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: floor quotient plus remainder-based rounding decision, then clip.
   function automatic logic [OW:0] model(input longint x, input int s, input int mode);
      int l;
      longint q, r, half;
      l = 15 - s * 2;
      q = x >>> l;
      r = x - (q <<< l);
      half = (l > 0) ? (longint'(1) <<< (l - 1)) : 64'sd0;
      if (l > 0) begin
         if (mode == 1 && r >= half) q++;
         else if (mode == 2 && (r > half || (r == half && q[0]))) q++;
      end
      if (q > 2047) return {1'b1, 12'h7ff};
      else if (q < -2048) return {1'b1, 12'h800};
      else return {1'b0, q[OW-1:0]};
   endfunction

   task automatic send(input logic [SW-1:0] s, input longint x, input logic [1:0] e);
      sel = s;
      ast_sink_data = x[IW-1:0];
      ast_sink_error = e;
      ast_sink_valid = 1'b1;
      exp_q.push_back({e, model(x, int'(s), 0), model(x, int'(s), 1), model(x, int'(s), 2)});
      @(posedge clk);
      #1;
      ast_sink_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      ast_sink_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard side: pop one expectation per output sample.
   always @(negedge clk) begin
      if (valid_m0 || valid_m1 || valid_m2) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {valid_m0, valid_m1, valid_m2}, 0);
         end else begin
            exp_e = exp_q.pop_front();
            check("valid_all", {valid_m0, valid_m1, valid_m2}, 3'b111);
            check("sample", {err_m1, flag_m0, data_m0, flag_m1, data_m1, flag_m2, data_m2}, exp_e);
            check("error_m0_m2", {err_m0, err_m2}, {exp_e[EW-1:EW-2], exp_e[EW-1:EW-2]});
         end
      end else begin
         check("idle_flag", {flag_m0, flag_m1, flag_m2}, 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint xr;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {valid_m1, flag_m1, err_m1, data_m1}, 0);
      check("rst_count", cnt_m1, 0);
      reset_n = 1'b1;
      idle(2);

      // Latency: result appears after the third capturing edge.
      send(2'd0, longint'(1000) <<< 15, 2'b01);
      check("lat_stage1", valid_m1, 0);
      @(posedge clk); #1;
      check("lat_stage2", valid_m1, 0);
      @(posedge clk); #1;
      check("lat_out_valid", valid_m1, 1);
      check("lat_out_data", data_m1, 1000);
      check("lat_out_flag", flag_m1, 0);
      idle(4);

      // Saturation at both rails, including overflow from rounding alone.
      send(2'd0, longint'(2048) <<< 15, 2'b00);
      send(2'd0, -(longint'(3000) <<< 15), 2'b10);
      send(2'd0, (longint'(2047) <<< 15) + (longint'(1) <<< 14), 2'b11);
      // Ties: modes disagree.
      send(2'd0, (longint'(5) <<< 15) + (longint'(1) <<< 14), 2'b00);
      send(2'd0, (longint'(4) <<< 15) + (longint'(1) <<< 14), 2'b00);
      send(2'd0, -(longint'(5) <<< 15) + (longint'(1) <<< 14), 2'b00);
      // Back-to-back windows.
      send(2'd0, longint'(1000) <<< 15, 2'b00);
      send(2'd3, longint'(1000) <<< 9, 2'b01);
      send(2'd3, longint'(1) <<< 20, 2'b00);
      send(2'd1, longint'(1000) <<< 13, 2'b00);
      send(2'd2, -(longint'(5) <<< 11) - (longint'(1) <<< 10), 2'b10);
      send(2'd2, longint'(-2048) <<< 11, 2'b00);
      idle(5);
      check("directed_drained", exp_q.size(), 0);

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            xr = {$urandom, $urandom};
            xr = xr >>> 29;
         end else begin
            xr = ((longint'($urandom_range(0, 8191)) - 4096) <<< $urandom_range(6, 15))
                 + longint'($urandom_range(0, 1023));
         end
         send(SW'($urandom_range(0, 3)), xr, 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(5);
      check("random_drained", exp_q.size(), 0);

`ifdef VARSAT_SAT_COUNTER_EN
      sat_count_clr = 1'b1;
      idle(1);
      sat_count_clr = 1'b0;
      check("cnt_cleared", cnt_m1, 0);
      for (int i = 0; i < 5; i++) send(2'd0, longint'(2048) <<< 15, 2'b00);
      idle(5);
      check("cnt_five", cnt_m1, 5);
      send(2'd0, longint'(2048) <<< 15, 2'b00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("clr_race_setup", {valid_m1, flag_m1}, 2'b11);
      sat_count_clr = 1'b1;
      @(posedge clk); #1;
      sat_count_clr = 1'b0;
      check("clr_beats_inc", cnt_m1, 0);
      for (int i = 0; i < 20; i++) send(2'd0, -(longint'(3000) <<< 15), 2'b00);
      idle(5);
      check("cnt_sticky", cnt_sm, 15);
      check("cnt_twenty", cnt_m1, 20);
`else
      for (int i = 0; i < 3; i++) send(2'd0, longint'(2048) <<< 15, 2'b00);
      sat_count_clr = 1'b1;
      idle(1);
      sat_count_clr = 1'b0;
      idle(5);
      check("cnt_absent", {cnt_m1, cnt_sm}, 0);
`endif

      // Reset with three samples in flight.
      send(2'd0, longint'(100) <<< 15, 2'b01);
      send(2'd0, longint'(200) <<< 15, 2'b10);
      send(2'd0, longint'(300) <<< 15, 2'b11);
      reset_n = 1'b0;
      #1;
      check("midrst_outputs", {valid_m1, flag_m1, err_m1, data_m1}, 0);
      check("midrst_count", cnt_m1, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(5);
      check("no_stale_valid", valid_m1, 0);
      send(2'd0, longint'(7) <<< 15, 2'b00);
      check("post_rst_lat1", valid_m1, 0);
      @(posedge clk); #1;
      check("post_rst_lat2", valid_m1, 0);
      @(posedge clk); #1;
      check("post_rst_out", {valid_m1, data_m1}, {1'b1, 12'd7});
      idle(5);
      check("final_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
